// File: rtl/output_port_ctrl.sv
// ---------------------------------------------------------------------------
// OutputPortCtrl
//
// Per-output control for a router crossbar. While idle, this block forwards
// the input ports' requests to an external fixed-priority arbiter. It takes
// the arbiter's one-hot grant, locks the output to that input for a whole
// packet (head through tail), and pops flits from the owner's input buffer.
// Flits are registered onto the output link. A downstream credit counter
// throttles the transfers.
//
// Ports:
//   CLK        - sole clock, rising edge
//   RST        - asynchronous active-high reset
//   REQ        - per-input head-flit request targeting this output
//   ARB_REQ    - gated request to the arbiter (idle, credits available)
//   GRT        - one-hot grant back from the arbiter (combinational)
//   FLIT_IN    - concatenated input flits, port i at [i*DW +: DW]
//   FLIT_VLD   - per-input flit valid
//   FLIT_TAIL  - per-input tail marker of the presented flit
//   POP        - dequeue strobe to the owner's input buffer
//   FLIT_OUT   - registered outgoing flit
//   VLD_OUT    - FLIT_OUT valid, one cycle per flit
//   TAIL_OUT   - FLIT_OUT is a tail flit
//   CREDIT_IN  - one-cycle credit return from downstream
//   LOCK       - a packet currently owns the output
//   ERR        - sticky credit-overflow flag
// ---------------------------------------------------------------------------
module output_port_ctrl #(
  parameter int NR      = 6,
  parameter int DW      = 32,
  parameter int CREDITS = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NR-1:0]    REQ,
  output logic [NR-1:0]    ARB_REQ,
  input  logic [NR-1:0]    GRT,
  input  logic [NR*DW-1:0] FLIT_IN,
  input  logic [NR-1:0]    FLIT_VLD,
  input  logic [NR-1:0]    FLIT_TAIL,
  output logic [NR-1:0]    POP,
  output logic [DW-1:0]    FLIT_OUT,
  output logic             VLD_OUT,
  output logic             TAIL_OUT,
  input  logic             CREDIT_IN,
  output logic             LOCK,
  output logic             ERR
);

  localparam int             CW      = $clog2(CREDITS + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CREDITS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [NR-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   flit_out_q, flit_out_d;
  logic            vld_out_q, vld_out_d;
  logic            tail_out_q, tail_out_d;
  logic            err_q, err_d;

  logic            has_credit;
  logic            transfer;
  logic [DW-1:0]   sel_data;
  logic            sel_tail;

  // Select the owner's flit slice and tail bit. OWNER is one-hot or zero,
  // so at most one iteration matches.
  always_comb begin
    sel_data = '0;
    sel_tail = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (owner_q[i]) begin
        sel_data = FLIT_IN[i*DW +: DW];
        sel_tail = FLIT_TAIL[i];
      end
    end
  end

  // A transfer needs a locked owner that presents a valid flit, plus at
  // least one downstream credit. Otherwise the packet just stalls in BUSY.
  always_comb begin
    has_credit = (cnt_q != '0);
    transfer   = (state_q == BUSY) && ((FLIT_VLD & owner_q) != '0) && has_credit;
  end

  // ARB_REQ and POP are gated by RST as well. The reset already forces the
  // state, but the outputs must read zero even during the reset itself.
  always_comb begin
    ARB_REQ = '0;
    POP     = '0;
    if (!RST && state_q == IDLE && has_credit) begin
      ARB_REQ = REQ;
    end
    if (!RST && transfer) begin
      POP = owner_q;
    end
  end

  // Next-state logic for the FSM, the output registers, and the credit
  // counter. A credit and a transfer in the same cycle cancel out. A credit
  // that arrives while the counter is already full is dropped and flagged.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    flit_out_d = flit_out_q;
    vld_out_d  = 1'b0;
    tail_out_d = 1'b0;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if ($onehot(GRT)) begin
          owner_d = GRT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (transfer) begin
          flit_out_d = sel_data;
          vld_out_d  = 1'b1;
          tail_out_d = sel_tail;
          if (sel_tail) begin
            owner_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase

    case ({transfer, CREDIT_IN})
      2'b10: cnt_d = cnt_q - CW'(1);
      2'b01: begin
        if (cnt_q == CNT_MAX) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // All state sits in this one register block. A reset in the middle of a
  // packet drops the packet, and the credit counter goes back to full.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      cnt_q      <= CNT_MAX;
      flit_out_q <= '0;
      vld_out_q  <= 1'b0;
      tail_out_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      flit_out_q <= flit_out_d;
      vld_out_q  <= vld_out_d;
      tail_out_q <= tail_out_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    FLIT_OUT = flit_out_q;
    VLD_OUT  = vld_out_q;
    TAIL_OUT = tail_out_q;
    LOCK     = (state_q == BUSY);
    ERR      = err_q;
  end

endmodule

// File: tb/tb_output_port_ctrl.sv
// ---------------------------------------------------------------------------
// TbOutputPortCtrl
//
// Self-checking bench for output_port_ctrl with NR=6, DW=8, CREDITS=4.
// A behavioural model tracks the following: whether a packet owns the
// output, the owner's port number, the credit count as a plain integer,
// the error flag, and the expected output register contents. The bench
// runs the directed scenarios first and then a randomized phase.
// ---------------------------------------------------------------------------
module tb_output_port_ctrl;

  localparam int NR      = 6;
  localparam int DW      = 8;
  localparam int CREDITS = 4;

  logic             CLK;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR-1:0]    arbReq;
  logic [NR-1:0]    grt;
  logic [NR*DW-1:0] flitIn;
  logic [NR-1:0]    flitVld;
  logic [NR-1:0]    flitTail;
  logic [NR-1:0]    pop;
  logic [DW-1:0]    flitOut;
  logic             vldOut;
  logic             tailOut;
  logic             creditIn;
  logic             lock;
  logic             err;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state
  bit          mBusy;
  int          mOwner;
  int          mCnt;
  bit          mErr;
  logic [7:0]  mFlit;
  bit          mVld;
  bit          mTail;

  output_port_ctrl #(.NR(NR), .DW(DW), .CREDITS(CREDITS)) dut (
    .CLK       (CLK),
    .RST       (rst),
    .REQ       (req),
    .ARB_REQ   (arbReq),
    .GRT       (grt),
    .FLIT_IN   (flitIn),
    .FLIT_VLD  (flitVld),
    .FLIT_TAIL (flitTail),
    .POP       (pop),
    .FLIT_OUT  (flitOut),
    .VLD_OUT   (vldOut),
    .TAIL_OUT  (tailOut),
    .CREDIT_IN (creditIn),
    .LOCK      (lock),
    .ERR       (err)
  );

  // 10 ns clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Every comparison is counted here, and each mismatch is reported here
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Puts flit value val on port p, with zeros on all other ports
  function automatic logic [NR*DW-1:0] flitFor(input int p, input logic [7:0] val);
    logic [NR*DW-1:0] v;
    v = '0;
    v[p*DW +: DW] = val;
    return v;
  endfunction

  task automatic modelReset();
    mBusy  = 1'b0;
    mOwner = -1;
    mCnt   = CREDITS;
    mErr   = 1'b0;
    mFlit  = '0;
    mVld   = 1'b0;
    mTail  = 1'b0;
  endtask

  // Runs one clock cycle with the current inputs. At mid-cycle it checks
  // ARB_REQ and POP against the model. It then advances the model by the
  // behavioural rules and checks the registered outputs just after the edge.
  task automatic stepCycle();
    logic [NR-1:0] expArb;
    logic [NR-1:0] expPop;
    bit            xfer;
    int            ones;
    int            idx;
    @(negedge CLK);
    expArb = (!mBusy && mCnt > 0) ? req : '0;
    xfer   = 1'b0;
    if (mBusy && mCnt > 0) xfer = flitVld[mOwner];
    expPop = xfer ? NR'(1 << mOwner) : '0;
    checkOutput("arbReq", {58'd0, arbReq}, {58'd0, expArb});
    checkOutput("pop", {58'd0, pop}, {58'd0, expPop});

    if (!mBusy) begin
      ones = 0;
      idx  = -1;
      for (int i = 0; i < NR; i++) begin
        if (grt[i]) begin
          ones++;
          idx = i;
        end
      end
      mVld  = 1'b0;
      mTail = 1'b0;
      if (ones == 1) begin
        mBusy  = 1'b1;
        mOwner = idx;
      end
    end else if (xfer) begin
      mFlit = flitIn[mOwner*DW +: DW];
      mVld  = 1'b1;
      mTail = flitTail[mOwner];
      if (mTail) begin
        mBusy  = 1'b0;
        mOwner = -1;
      end
    end else begin
      mVld  = 1'b0;
      mTail = 1'b0;
    end

    if (xfer && !creditIn) begin
      mCnt = mCnt - 1;
    end else if (creditIn && !xfer) begin
      if (mCnt == CREDITS) mErr = 1'b1;
      else mCnt = mCnt + 1;
    end

    @(posedge CLK);
    #1;
    checkOutput("vldOut", {63'd0, vldOut}, {63'd0, mVld});
    checkOutput("tailOut", {63'd0, tailOut}, {63'd0, mTail});
    checkOutput("flitOut", {56'd0, flitOut}, {56'd0, mFlit});
    checkOutput("lock", {63'd0, lock}, {63'd0, mBusy});
    checkOutput("err", {63'd0, err}, {63'd0, mErr});
    checkOutput("cnt", 64'(dut.cnt_q), 64'(mCnt));
  endtask

  // Drives one cycle's inputs and runs that cycle
  task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR-1:0] g,
                               input logic [NR-1:0] v, input logic [NR-1:0] t,
                               input logic [NR*DW-1:0] d, input logic c);
    req      = r;
    grt      = g;
    flitVld  = v;
    flitTail = t;
    flitIn   = d;
    creditIn = c;
    stepCycle();
  endtask

  // Asserts the asynchronous reset mid-cycle, without waiting for a clock
  // edge. It checks the reset values while the reset is held, then
  // releases the reset one cycle later.
  task automatic applyReset();
    rst = 1'b1;
    #2;
    modelReset();
    checkOutput("rstArbReq", {58'd0, arbReq}, 64'd0);
    checkOutput("rstPop", {58'd0, pop}, 64'd0);
    checkOutput("rstVld", {63'd0, vldOut}, 64'd0);
    checkOutput("rstTail", {63'd0, tailOut}, 64'd0);
    checkOutput("rstFlit", {56'd0, flitOut}, 64'd0);
    checkOutput("rstLock", {63'd0, lock}, 64'd0);
    checkOutput("rstCnt", 64'(dut.cnt_q), 64'(CREDITS));
    checkOutput("rstErr", {63'd0, err}, 64'd0);
    checkOutput("rstOwner", 64'(dut.owner_q), 64'd0);
    @(posedge CLK);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    grt      = '0;
    flitIn   = '0;
    flitVld  = '0;
    flitTail = '0;
    creditIn = 1'b0;
    modelReset();
    @(posedge CLK);
    #1;

    // Reset while every port requests
    req = 6'b111111;
    applyReset();

    // Three-flit packet on port 2
    applyStimulus(6'b000100, 6'b000100, '0, '0, '0, 1'b0);
    applyStimulus('0, '0, 6'b000100, '0, flitFor(2, 8'hA1), 1'b0);
    applyStimulus('0, '0, 6'b000100, '0, flitFor(2, 8'hA2), 1'b0);
    applyStimulus('0, '0, 6'b000100, 6'b000100, flitFor(2, 8'hA3), 1'b0);
    checkOutput("p2Flit", {56'd0, flitOut}, 64'hA3);
    checkOutput("p2Tail", {63'd0, tailOut}, 64'd1);
    checkOutput("p2Lock", {63'd0, lock}, 64'd0);
    checkOutput("p2Cnt", 64'(dut.cnt_q), 64'd1);
    applyStimulus('0, '0, '0, '0, '0, 1'b0);

    // Credit stall: a five-flit packet with only four credits
    applyReset();
    applyStimulus(6'b000001, 6'b000001, '0, '0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus('0, '0, 6'b000001, (k == 4) ? 6'b000001 : 6'b000000,
                    flitFor(0, 8'(8'h10 + k)), 1'b0);
    end
    applyStimulus('0, '0, 6'b000001, 6'b000001, flitFor(0, 8'h14), 1'b0);
    checkOutput("stallLock", {63'd0, lock}, 64'd1);
    checkOutput("stallCnt", 64'(dut.cnt_q), 64'd0);
    applyStimulus('0, '0, 6'b000001, 6'b000001, flitFor(0, 8'h14), 1'b1);
    applyStimulus('0, '0, 6'b000001, 6'b000001, flitFor(0, 8'h14), 1'b0);
    checkOutput("stallFlit5", {56'd0, flitOut}, 64'h14);
    checkOutput("stallCntEnd", 64'(dut.cnt_q), 64'd0);

    // Grant changes during a port 5 packet must not move the lock
    applyReset();
    applyStimulus(6'b100000, 6'b100000, '0, '0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'b111111, 6'b000001, 6'b111111, (k == 2) ? 6'b100000 : 6'b000000,
                    flitFor(5, 8'(8'h50 + k)), 1'b0);
      if (k < 2) checkOutput("lockOwner", 64'(dut.owner_q), 64'h20);
    end
    checkOutput("lockOwnerEnd", 64'(dut.owner_q), 64'd0);

    // A credit in the same cycle as a transfer, then an overflow credit
    applyReset();
    applyStimulus(6'b000010, 6'b000010, '0, '0, '0, 1'b0);
    applyStimulus('0, '0, 6'b000010, '0, flitFor(1, 8'h11), 1'b1);
    applyStimulus('0, '0, 6'b000010, 6'b000010, flitFor(1, 8'h12), 1'b1);
    checkOutput("coCnt", 64'(dut.cnt_q), 64'd4);
    applyStimulus('0, '0, '0, '0, '0, 1'b1);
    checkOutput("ovfErr", {63'd0, err}, 64'd1);
    checkOutput("ovfCnt", 64'(dut.cnt_q), 64'd4);
    applyStimulus('0, '0, '0, '0, '0, 1'b0);
    applyStimulus('0, '0, '0, '0, '0, 1'b0);
    checkOutput("ovfSticky", {63'd0, err}, 64'd1);

    // Reset in the middle of a packet, then a clean new packet
    applyReset();
    applyStimulus(6'b001000, 6'b001000, '0, '0, '0, 1'b0);
    applyStimulus('0, '0, 6'b001000, '0, flitFor(3, 8'h31), 1'b0);
    applyStimulus('0, '0, 6'b001000, '0, flitFor(3, 8'h32), 1'b0);
    flitIn = flitFor(3, 8'h33);
    applyReset();
    applyStimulus('0, '0, 6'b001000, '0, flitFor(3, 8'h33), 1'b0);
    checkOutput("mrCnt", 64'(dut.cnt_q), 64'd4);
    applyStimulus(6'b010000, 6'b010000, '0, '0, '0, 1'b0);
    applyStimulus('0, '0, 6'b010000, 6'b010000, flitFor(4, 8'h41), 1'b0);
    checkOutput("mrFlit", {56'd0, flitOut}, 64'h41);
    checkOutput("mrCntEnd", 64'(dut.cnt_q), 64'd3);

    // Randomized traffic against the model
    applyReset();
    for (int n = 0; n < 600; n++) begin
      logic [NR-1:0] g;
      logic [NR-1:0] v;
      logic [NR-1:0] t;
      case ($urandom_range(0, 3))
        0:       g = '0;
        3:       g = NR'($urandom());
        default: g = NR'(1 << $urandom_range(0, NR - 1));
      endcase
      for (int i = 0; i < NR; i++) begin
        v[i] = ($urandom_range(0, 9) < 7);
        t[i] = ($urandom_range(0, 9) < 3);
      end
      if ($urandom_range(0, 99) == 0) begin
        applyReset();
      end
      applyStimulus(NR'($urandom()), g, v, t, (NR*DW)'({$urandom(), $urandom()}),
                    ($urandom_range(0, 9) < 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/output_port_ctrl.md
OUTPUT_PORT_CTRL -- requirements
Module: output_port_ctrl

Interface
REQ-001 SHALL have parameter NR, default 6, number of input ports competing for this output.
REQ-002 SHALL have parameter DW, default 32, flit data width in bits.
REQ-003 SHALL have parameter CREDITS, default 4, downstream buffer depth in flits.
REQ-004 SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port REQ  input  NR  per-port head-flit request targeting this output.
REQ-007 SHALL have port ARB_REQ  output  NR  gated request to the fixed-priority arbiter.
REQ-008 SHALL have port GRT  input  NR  combinational one-hot grant returned by the arbiter.
REQ-009 SHALL have port FLIT_IN  input  NR*DW  concatenated flit data; port i occupies bits [i*DW +: DW].
REQ-010 SHALL have port FLIT_VLD  input  NR  per-port flit valid.
REQ-011 SHALL have port FLIT_TAIL  input  NR  per-port tail marker for the presented flit.
REQ-012 SHALL have port POP  output  NR  dequeue strobe to the input buffers; at most one bit set.
REQ-013 SHALL have port FLIT_OUT  output  DW  registered outgoing flit.
REQ-014 SHALL have port VLD_OUT  output  1  FLIT_OUT valid, one cycle per flit.
REQ-015 SHALL have port TAIL_OUT  output  1  FLIT_OUT is a tail flit.
REQ-016 SHALL have port CREDIT_IN  input  1  one-cycle credit return from downstream.
REQ-017 SHALL have port LOCK  output  1  high while a packet owns the output (state BUSY).
REQ-018 SHALL have port ERR  output  1  sticky credit-overflow flag.

Function
REQ-019 SHALL implement a two-state FSM: IDLE and BUSY; registered OWNER[NR-1:0] and CNT[$clog2(CREDITS+1)-1:0].
REQ-020 SHALL drive ARB_REQ = REQ when state=IDLE, RST=0 and CNT>0; otherwise all zeros.
REQ-021 In IDLE, if GRT is exactly one-hot, SHALL latch OWNER<=GRT and enter BUSY next edge; zero or multi-hot GRT SHALL be ignored (stay IDLE).
REQ-022 In BUSY, a transfer SHALL occur in a cycle when FLIT_VLD&OWNER is nonzero and CNT>0; POP=OWNER combinationally in that cycle, else POP=0.
REQ-023 On a transfer edge SHALL register FLIT_OUT<=owner slice of FLIT_IN, TAIL_OUT<=owner bit of FLIT_TAIL, VLD_OUT<=1; latency POP-to-VLD_OUT one cycle.
REQ-024 In non-transfer cycles SHALL register VLD_OUT<=0 and TAIL_OUT<=0; FLIT_OUT holds its last value.
REQ-025 Transfer with owner tail bit set SHALL return to IDLE and clear OWNER at that edge; head=tail single-flit packets are legal.
REQ-026 GRT changes during BUSY SHALL be ignored; OWNER is stable until tail transfer.
REQ-027 Minimum gap between packets SHALL be one cycle (the IDLE arbitration cycle).
REQ-028 CNT SHALL decrement on transfer, increment on CREDIT_IN, and hold when both occur in the same cycle.
REQ-029 CREDIT_IN with CNT=CREDITS and no transfer SHALL leave CNT at CREDITS and set ERR=1 until reset.
REQ-030 CNT=0 SHALL stall transfers (POP=0) without leaving BUSY; a FLIT_VLD gap on the owner SHALL likewise stall without leaving BUSY.

Reset
REQ-031 RST high SHALL asynchronously force: state=IDLE, OWNER=0, CNT=CREDITS, FLIT_OUT=0, VLD_OUT=0, TAIL_OUT=0, ERR=0; ARB_REQ=0 and POP=0 while RST is high.
REQ-032 Reset mid-packet SHALL abandon the packet; no residual POP or VLD_OUT after release.

Verification (NR=6, DW=8, CREDITS=4)
REQ-033 Reset: RST=1 with REQ=6'b111111 -> ARB_REQ=0, POP=0, VLD_OUT=0, LOCK=0, CNT=4, ERR=0.
REQ-034 Port 2 packet 0xA1,0xA2,0xA3(tail), GRT=6'b000100 -> POP=6'b000100 three cycles; FLIT_OUT A1,A2,A3 one cycle later, TAIL_OUT with A3; LOCK falls after tail; CNT=1.
REQ-035 Credit stall: 5-flit packet on port 0, no CREDIT_IN -> 4 flits out, POP=0 with LOCK=1; one CREDIT_IN pulse -> 5th flit out the next cycle, CNT=0.
REQ-036 Lock: during port 5 packet drive REQ=6'b111111, GRT=6'b000001 -> ARB_REQ=0, OWNER stays 6'b100000 until tail.
REQ-037 Credits: CREDIT_IN coincident with a transfer -> CNT unchanged; CREDIT_IN at CNT=4 -> CNT=4, ERR=1 sticky.
REQ-038 Mid-packet reset after 2 of 4 flits -> all outputs at reset values; after release a new grant starts a clean packet with CNT=4.
